// File: rtl/rename_map_unit.sv
// Register rename stage: maps a group of WIDTH uops per cycle onto physical
// registers, allocates destinations from a circular free list, and restores
// the speculative map from the committed map on flush.
module rename_map_unit #(
    parameter int WIDTH        = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int NUM_AREGS    = 32,
    parameter int NUM_PREGS    = 64,
    localparam int AW    = $clog2(NUM_AREGS),
    localparam int PW    = $clog2(NUM_PREGS),
    localparam int DEPTH = NUM_PREGS - NUM_AREGS,
    localparam int DW    = $clog2(DEPTH),
    localparam int CW    = DW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_valid,
    input  logic [WIDTH*AW-1:0]        in_src1,
    input  logic [WIDTH*AW-1:0]        in_src2,
    input  logic [WIDTH*AW-1:0]        in_dst,
    input  logic [WIDTH-1:0]           in_has_dst,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_lane_valid,
    output logic [WIDTH*PW-1:0]        out_psrc1,
    output logic [WIDTH*PW-1:0]        out_psrc2,
    output logic [WIDTH*PW-1:0]        out_pdst,
    output logic [WIDTH*PW-1:0]        out_old_pdst,
    input  logic [COMMIT_WIDTH-1:0]    commit_valid,
    input  logic [COMMIT_WIDTH-1:0]    commit_has_dst,
    input  logic [COMMIT_WIDTH*AW-1:0] commit_areg,
    input  logic [COMMIT_WIDTH*PW-1:0] commit_pdst,
    input  logic [COMMIT_WIDTH*PW-1:0] commit_old_pdst,
    input  logic                       flush,
    output logic [CW-1:0]              free_count
);

    logic [PW-1:0] rat_spec     [NUM_AREGS];
    logic [PW-1:0] rat_cmt      [NUM_AREGS];
    logic [PW-1:0] fl           [DEPTH];
    logic [PW-1:0] rat_spec_nxt [NUM_AREGS];
    logic [PW-1:0] rat_cmt_nxt  [NUM_AREGS];
    logic [PW-1:0] fl_nxt       [DEPTH];
    logic [CW-1:0] rd_ptr, cmt_rd_ptr, wr_ptr;
    logic [CW-1:0] alloc_cnt, cmt_cnt;
    logic [WIDTH-1:0] need;
    logic [PW-1:0] lane_pdst [WIDTH];
    logic [PW-1:0] lane_ps1  [WIDTH];
    logic [PW-1:0] lane_ps2  [WIDTH];
    logic [PW-1:0] lane_old  [WIDTH];
    logic [WIDTH*PW-1:0] psrc1_nxt, psrc2_nxt, pdst_nxt, old_nxt;
    logic accept;

    // Readiness is conservative: a full group's worth of free pregs is required
    assign free_count = wr_ptr - rd_ptr;
    assign in_ready   = !flush && (!out_valid || out_ready) && (free_count >= CW'(WIDTH));
    assign accept     = in_ready && (|in_valid);

    // Compacted allocation: needing lanes take consecutive free-list entries
    always_comb begin
        alloc_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            need[i]      = in_valid[i] & in_has_dst[i] & (in_dst[i*AW +: AW] != '0);
            lane_pdst[i] = '0;
            if (need[i]) begin
                lane_pdst[i] = fl[DW'(rd_ptr + alloc_cnt)];
                alloc_cnt    = alloc_cnt + CW'(1);
            end
        end
    end

    // Source/old mapping with forwarding from the highest earlier allocating lane
    always_comb begin
        rat_spec_nxt = rat_spec;
        for (int i = 0; i < WIDTH; i++) begin
            lane_ps1[i] = rat_spec[in_src1[i*AW +: AW]];
            lane_ps2[i] = rat_spec[in_src2[i*AW +: AW]];
            lane_old[i] = rat_spec[in_dst[i*AW +: AW]];
            for (int j = 0; j < WIDTH; j++) begin
                if (j < i && need[j]) begin
                    if (in_dst[j*AW +: AW] == in_src1[i*AW +: AW]) lane_ps1[i] = lane_pdst[j];
                    if (in_dst[j*AW +: AW] == in_src2[i*AW +: AW]) lane_ps2[i] = lane_pdst[j];
                    if (in_dst[j*AW +: AW] == in_dst[i*AW +: AW])  lane_old[i] = lane_pdst[j];
                end
            end
            if (in_src1[i*AW +: AW] == '0) lane_ps1[i] = '0;
            if (in_src2[i*AW +: AW] == '0) lane_ps2[i] = '0;
            if (need[i]) rat_spec_nxt[in_dst[i*AW +: AW]] = lane_pdst[i];
        end
    end

    // Commit: update committed map and return old pregs to the free list tail
    always_comb begin
        cmt_cnt     = '0;
        rat_cmt_nxt = rat_cmt;
        fl_nxt      = fl;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_valid[k] && commit_has_dst[k] && (commit_areg[k*AW +: AW] != '0)) begin
                rat_cmt_nxt[commit_areg[k*AW +: AW]] = commit_pdst[k*PW +: PW];
                fl_nxt[DW'(wr_ptr + cmt_cnt)]        = commit_old_pdst[k*PW +: PW];
                cmt_cnt = cmt_cnt + CW'(1);
            end
        end
    end

    // Pack per-lane results for the output register
    always_comb begin
        psrc1_nxt = '0;
        psrc2_nxt = '0;
        pdst_nxt  = '0;
        old_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            psrc1_nxt[i*PW +: PW] = lane_ps1[i];
            psrc2_nxt[i*PW +: PW] = lane_ps2[i];
            pdst_nxt[i*PW +: PW]  = lane_pdst[i];
            old_nxt[i*PW +: PW]   = lane_old[i];
        end
    end

    // State update; flush applies this cycle's commits before restoring the map
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_AREGS; a++) begin
                rat_spec[a] <= PW'(a);
                rat_cmt[a]  <= PW'(a);
            end
            for (int k = 0; k < DEPTH; k++) fl[k] <= PW'(NUM_AREGS + k);
            rd_ptr         <= '0;
            cmt_rd_ptr     <= '0;
            wr_ptr         <= CW'(DEPTH);
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
            out_psrc1      <= '0;
            out_psrc2      <= '0;
            out_pdst       <= '0;
            out_old_pdst   <= '0;
        end else begin
            rat_cmt    <= rat_cmt_nxt;
            fl         <= fl_nxt;
            wr_ptr     <= wr_ptr + cmt_cnt;
            cmt_rd_ptr <= cmt_rd_ptr + cmt_cnt;
            if (flush) begin
                rat_spec  <= rat_cmt_nxt;
                rd_ptr    <= cmt_rd_ptr + cmt_cnt;
                out_valid <= 1'b0;
            end else if (accept) begin
                rat_spec       <= rat_spec_nxt;
                rd_ptr         <= rd_ptr + alloc_cnt;
                out_valid      <= 1'b1;
                out_lane_valid <= in_valid;
                out_psrc1      <= psrc1_nxt;
                out_psrc2      <= psrc2_nxt;
                out_pdst       <= pdst_nxt;
                out_old_pdst   <= old_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rename_map_unit.sv
// Self-checking bench for rename_map_unit: directed scenarios plus random
// traffic, compared against a lane-sequential reference model.
module tb_rename_map_unit;
    localparam int W = 4, CWD = 4, NA = 32, AW = 5, PW = 6, DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0] in_valid, in_has_dst;
    logic [W*AW-1:0] in_src1, in_src2, in_dst;
    logic in_ready, out_valid, out_ready, flush;
    logic [W-1:0] out_lane_valid;
    logic [W*PW-1:0] out_psrc1, out_psrc2, out_pdst, out_old_pdst;
    logic [CWD-1:0] commit_valid, commit_has_dst;
    logic [CWD*AW-1:0] commit_areg;
    logic [CWD*PW-1:0] commit_pdst, commit_old_pdst;
    logic [5:0] free_count;

    always #5 clk = ~clk;

    rename_map_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_src1(in_src1), .in_src2(in_src2),
        .in_dst(in_dst), .in_has_dst(in_has_dst), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_lane_valid(out_lane_valid), .out_psrc1(out_psrc1),
        .out_psrc2(out_psrc2), .out_pdst(out_pdst), .out_old_pdst(out_old_pdst),
        .commit_valid(commit_valid), .commit_has_dst(commit_has_dst), .commit_areg(commit_areg),
        .commit_pdst(commit_pdst), .commit_old_pdst(commit_old_pdst), .flush(flush),
        .free_count(free_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model
    typedef struct { int areg; int pdst; int old; } rob_t;
    int   m_spec [NA];
    int   m_cmt  [NA];
    int   free_q [$];
    int   spec_n;
    bit   m_ov;
    bit [W-1:0] e_lv;
    int   e_ps1 [W], e_ps2 [W], e_pd [W], e_old [W];
    bit   e_need [W];
    rob_t rob [$];

    function automatic int lane(logic [W*PW-1:0] v, int i);
        return int'(v[i*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int a = 0; a < NA; a++) begin m_spec[a] = a; m_cmt[a] = a; end
        free_q = {};
        for (int k = 0; k < DEPTH; k++) free_q.push_back(NA + k);
        spec_n = 0; m_ov = 0; e_lv = '0; rob = {};
        for (int i = 0; i < W; i++) begin
            e_ps1[i] = 0; e_ps2[i] = 0; e_pd[i] = 0; e_old[i] = 0; e_need[i] = 0;
        end
    endtask

    task automatic clear_inputs();
        rst = 0; flush = 0; out_ready = 1;
        in_valid = '0; in_has_dst = '0; in_src1 = '0; in_src2 = '0; in_dst = '0;
        commit_valid = '0; commit_has_dst = '0; commit_areg = '0;
        commit_pdst = '0; commit_old_pdst = '0;
    endtask

    task automatic set_lane(int i, int d, int s1, int s2);
        in_valid[i] = 1'b1; in_has_dst[i] = 1'b1;
        in_dst[i*AW +: AW] = AW'(d); in_src1[i*AW +: AW] = AW'(s1); in_src2[i*AW +: AW] = AW'(s2);
    endtask

    task automatic commit_front(int k);
        for (int l = 0; l < k; l++) begin
            commit_valid[l] = 1; commit_has_dst[l] = 1;
            commit_areg[l*AW +: AW]     = AW'(rob[l].areg);
            commit_pdst[l*PW +: PW]     = PW'(rob[l].pdst);
            commit_old_pdst[l*PW +: PW] = PW'(rob[l].old);
        end
    endtask

    // one clock: check combinational outputs, advance model, check registered outputs
    task automatic step();
        bit rdy, acc;
        int s1, s2, d, p;
        #1;
        if (rst) begin
            @(posedge clk);
            model_reset();
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_lane_valid", out_lane_valid, 0);
            check("rst_pdst", out_pdst, 0);
            check("rst_free", free_count, DEPTH);
            return;
        end
        check("free_count", free_count, free_q.size() - spec_n);
        rdy = !flush && (!m_ov || out_ready) && (free_q.size() - spec_n >= W);
        check("in_ready", in_ready, rdy);
        acc = rdy && (in_valid != 0);
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                s1 = int'(in_src1[i*AW +: AW]); s2 = int'(in_src2[i*AW +: AW]); d = int'(in_dst[i*AW +: AW]);
                e_ps1[i]  = (s1 == 0) ? 0 : m_spec[s1];
                e_ps2[i]  = (s2 == 0) ? 0 : m_spec[s2];
                e_old[i]  = m_spec[d];
                e_need[i] = in_valid[i] && in_has_dst[i] && d != 0;
                e_pd[i]   = 0;
                if (e_need[i]) begin
                    p = free_q[spec_n]; spec_n++;
                    e_pd[i] = p; m_spec[d] = p;
                    rob.push_back('{d, p, e_old[i]});
                end
            end
            e_lv = in_valid; m_ov = 1;
        end else if (out_ready) m_ov = 0;
        for (int k = 0; k < CWD; k++) begin
            if (commit_valid[k] && commit_has_dst[k] && commit_areg[k*AW +: AW] != 0) begin
                m_cmt[int'(commit_areg[k*AW +: AW])] = int'(commit_pdst[k*PW +: PW]);
                void'(free_q.pop_front());
                free_q.push_back(int'(commit_old_pdst[k*PW +: PW]));
                spec_n--;
                void'(rob.pop_front());
            end
        end
        if (flush) begin
            m_spec = m_cmt; spec_n = 0; m_ov = 0; rob = {};
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("lane_valid", out_lane_valid, e_lv);
            for (int i = 0; i < W; i++) begin
                check("psrc1", lane(out_psrc1, i), e_ps1[i]);
                check("psrc2", lane(out_psrc2, i), e_ps2[i]);
                check("pdst", lane(out_pdst, i), e_pd[i]);
                if (e_need[i]) check("old_pdst", lane(out_old_pdst, i), e_old[i]);
            end
        end
    endtask

    task automatic do_reset();
        clear_inputs(); rst = 1; step(); rst = 0;
    endtask

    task automatic rand_cycle();
        int k, placed, hi;
        clear_inputs();
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 19) == 0);
        rst       = ($urandom_range(0, 499) == 0);
        hi = $urandom_range(0, 1) ? 7 : 31;
        for (int i = 0; i < W; i++) begin
            in_valid[i]   = $urandom_range(0, 1);
            in_has_dst[i] = ($urandom_range(0, 3) != 0);
            in_dst[i*AW +: AW]  = AW'($urandom_range(0, hi));
            in_src1[i*AW +: AW] = AW'($urandom_range(0, hi));
            in_src2[i*AW +: AW] = AW'($urandom_range(0, hi));
        end
        k = (rob.size() == 0) ? 0 : $urandom_range(0, (rob.size() < CWD) ? rob.size() : CWD);
        placed = 0;
        for (int l = 0; l < CWD; l++) begin
            if (placed < k && ((CWD - l) == (k - placed) || $urandom_range(0, 1) == 1)) begin
                commit_valid[l] = 1; commit_has_dst[l] = 1;
                commit_areg[l*AW +: AW]     = AW'(rob[placed].areg);
                commit_pdst[l*PW +: PW]     = PW'(rob[placed].pdst);
                commit_old_pdst[l*PW +: PW] = PW'(rob[placed].old);
                placed++;
            end else begin
                commit_valid[l] = $urandom_range(0, 1);
                commit_has_dst[l] = $urandom_range(0, 1);
                commit_areg[l*AW +: AW] = commit_has_dst[l] ? '0 : AW'($urandom_range(1, 31));
                commit_pdst[l*PW +: PW] = PW'($urandom_range(0, 63));
                commit_old_pdst[l*PW +: PW] = PW'($urandom_range(0, 63));
            end
        end
        step();
    endtask

    int saved;

    initial begin
        model_reset();
        // single lane x5 <- x1,x2
        do_reset();
        clear_inputs(); set_lane(0, 5, 1, 2); step();
        check("t1_psrc1", lane(out_psrc1, 0), 1);
        check("t1_psrc2", lane(out_psrc2, 0), 2);
        check("t1_pdst", lane(out_pdst, 0), 32);
        check("t1_old", lane(out_old_pdst, 0), 5);
        check("t1_free", free_count, 31);

        // intra-group forwarding
        do_reset();
        clear_inputs();
        set_lane(0, 3, 1, 0); set_lane(1, 4, 3, 0); set_lane(2, 3, 3, 4); set_lane(3, 7, 3, 0);
        step();
        for (int i = 0; i < W; i++) check("t2_pdst", lane(out_pdst, i), 32 + i);
        check("t2_l1_ps1", lane(out_psrc1, 1), 32);
        check("t2_l2_ps1", lane(out_psrc1, 2), 32);
        check("t2_l2_ps2", lane(out_psrc2, 2), 33);
        check("t2_l2_old", lane(out_old_pdst, 2), 32);
        check("t2_l3_ps1", lane(out_psrc1, 3), 34);
        clear_inputs(); set_lane(0, 9, 3, 0); step();
        check("t2_next_ps1", lane(out_psrc1, 0), 34);

        // x0 handling
        do_reset();
        clear_inputs(); set_lane(0, 0, 1, 0); set_lane(1, 2, 0, 0); step();
        check("t3_l0_pdst", lane(out_pdst, 0), 0);
        check("t3_l1_ps1", lane(out_psrc1, 1), 0);
        check("t3_l1_pdst", lane(out_pdst, 1), 32);
        check("t3_free", free_count, 31);

        // exhaustion and refill
        do_reset();
        for (int g = 0; g < 8; g++) begin
            clear_inputs();
            for (int i = 0; i < W; i++) set_lane(i, (g == 0) ? 1 + i : 8 + i, 0, 0);
            step();
        end
        check("t4_free0", free_count, 0);
        clear_inputs(); for (int i = 0; i < W; i++) set_lane(i, 20 + i, 0, 0);
        step();
        check("t4_ready_low", in_ready, 0);
        clear_inputs(); commit_front(4); step();
        clear_inputs();
        check("t4_ready_high", in_ready, 1);
        check("t4_free4", free_count, 4);
        for (int i = 0; i < W; i++) set_lane(i, 20 + i, 0, 0);
        step();
        for (int i = 0; i < W; i++) check("t4_refill_pdst", lane(out_pdst, i), 1 + i);

        // flush with a same-cycle commit
        do_reset();
        clear_inputs(); set_lane(0, 5, 0, 0); set_lane(1, 6, 0, 0); set_lane(2, 7, 0, 0); step();
        clear_inputs(); commit_front(1); flush = 1; step();
        check("t5_out_valid", out_valid, 0);
        clear_inputs(); set_lane(0, 8, 5, 0); step();
        check("t5_ps1", lane(out_psrc1, 0), 32);
        check("t5_pdst", lane(out_pdst, 0), 33);

        // backpressure
        do_reset();
        clear_inputs(); out_ready = 0; set_lane(0, 5, 1, 0); step();
        saved = lane(out_pdst, 0);
        for (int c = 0; c < 3; c++) begin
            clear_inputs(); out_ready = 0; set_lane(0, 6, 5, 0); step();
            check("t6_hold_pdst", lane(out_pdst, 0), saved);
            check("t6_hold_free", free_count, 31);
            check("t6_ready_low", in_ready, 0);
        end
        clear_inputs(); set_lane(0, 6, 5, 0); step();
        check("t6_release_pdst", lane(out_pdst, 0), 33);
        check("t6_release_ps1", lane(out_psrc1, 0), 32);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
